// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives F_PC into a combinational instruction memory,
// buffers returned words in a 2-entry queue and hands them to decode via valid/ready.
module instruction_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = {INSTR_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  F_PC,
    input  logic [INSTR_WIDTH-1:0] Instr,
    input  logic                   redirect_en,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   D_valid,
    input  logic                   D_ready,
    output logic [INSTR_WIDTH-1:0] D_Instr,
    output logic [ADDR_WIDTH-1:0]  D_PC,
    output logic [1:0]             fq_count,
    output logic                   halted
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_fpc;
    logic [CNT_W-1:0]       r_count;
    logic                   r_d_valid;
    logic [ADDR_WIDTH-1:0]  r_d_pc;
    logic [INSTR_WIDTH-1:0] r_d_instr;
    logic [ADDR_WIDTH-1:0]  r_s1_pc;
    logic [INSTR_WIDTH-1:0] r_s1_instr;
    logic                   r_halted;

    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  w_fpc_nxt;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   w_d_valid_nxt;
    logic [ADDR_WIDTH-1:0]  w_d_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_d_instr_nxt;
    logic [ADDR_WIDTH-1:0]  w_s1_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_s1_instr_nxt;
    logic                   w_halted_nxt;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_is_halt;

    // State and queue registers; the head slot doubles as the D_* output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_fpc      <= RESET_PC;
            r_count    <= '0;
            r_d_valid  <= 1'b0;
            r_d_pc     <= '0;
            r_d_instr  <= '0;
            r_s1_pc    <= '0;
            r_s1_instr <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fpc      <= w_fpc_nxt;
            r_count    <= w_count_nxt;
            r_d_valid  <= w_d_valid_nxt;
            r_d_pc     <= w_d_pc_nxt;
            r_d_instr  <= w_d_instr_nxt;
            r_s1_pc    <= w_s1_pc_nxt;
            r_s1_instr <= w_s1_instr_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    // Next-state: redirect overrides any push/pop in the same cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_fpc_nxt      = r_fpc;
        w_count_nxt    = r_count;
        w_d_pc_nxt     = r_d_pc;
        w_d_instr_nxt  = r_d_instr;
        w_s1_pc_nxt    = r_s1_pc;
        w_s1_instr_nxt = r_s1_instr;
        w_halted_nxt   = r_halted;

        w_pop     = r_d_valid & D_ready;
        w_push    = (r_state == ST_RUN) & ~redirect_en
                    & ((r_count < CNT_W'(2)) | w_pop);
        w_is_halt = (Instr == HALT_INSTR);

        if (redirect_en) begin
            w_count_nxt  = '0;
            w_fpc_nxt    = redirect_pc;
            w_state_nxt  = ST_RUN;
            w_halted_nxt = 1'b0;
        end else begin
            if (w_push) begin
                if (w_is_halt) begin
                    w_state_nxt  = ST_HALTED;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_fpc_nxt = r_fpc + ADDR_WIDTH'(1);
                end
            end

            if (w_push && w_pop) begin
                if (r_count == CNT_W'(2)) begin
                    w_d_pc_nxt     = r_s1_pc;
                    w_d_instr_nxt  = r_s1_instr;
                    w_s1_pc_nxt    = r_fpc;
                    w_s1_instr_nxt = Instr;
                end else begin
                    w_d_pc_nxt    = r_fpc;
                    w_d_instr_nxt = Instr;
                end
            end else if (w_push) begin
                if (r_count == CNT_W'(0)) begin
                    w_d_pc_nxt    = r_fpc;
                    w_d_instr_nxt = Instr;
                    w_count_nxt   = CNT_W'(1);
                end else begin
                    w_s1_pc_nxt    = r_fpc;
                    w_s1_instr_nxt = Instr;
                    w_count_nxt    = CNT_W'(2);
                end
            end else if (w_pop) begin
                if (r_count == CNT_W'(2)) begin
                    w_d_pc_nxt    = r_s1_pc;
                    w_d_instr_nxt = r_s1_instr;
                    w_count_nxt   = CNT_W'(1);
                end else begin
                    w_count_nxt = CNT_W'(0);
                end
            end
        end

        w_d_valid_nxt = (w_count_nxt != CNT_W'(0));
    end

    assign F_PC     = r_fpc;
    assign D_valid  = r_d_valid;
    assign D_Instr  = r_d_instr;
    assign D_PC     = r_d_pc;
    assign fq_count = r_count;
    assign halted   = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory word i = 32'h1000+i, optional halt word,
// second instance with RESET_PC = all-ones for wrap-around.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        D_ready;

    logic [31:0] F_PC0, Instr0, D_Instr0, D_PC0;
    logic        D_valid0, halted0;
    logic [1:0]  fq_count0;

    logic [31:0] F_PC1, Instr1, D_Instr1, D_PC1;
    logic        D_valid1, halted1;
    logic [1:0]  fq_count1;

    logic        halt_en;
    logic [31:0] halt_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Combinational instruction memory model
    always_comb begin
        if (halt_en && F_PC0 == halt_addr) Instr0 = 32'hFFFF_FFFF;
        else                               Instr0 = 32'h1000 + F_PC0;
        Instr1 = 32'h1000 + F_PC1;
    end

    instruction_fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0),
                             .HALT_INSTR(32'hFFFF_FFFF)) dut0 (
        .clk(clk), .reset(reset), .F_PC(F_PC0), .Instr(Instr0),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .D_valid(D_valid0), .D_ready(D_ready), .D_Instr(D_Instr0),
        .D_PC(D_PC0), .fq_count(fq_count0), .halted(halted0)
    );

    instruction_fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFFF),
                             .HALT_INSTR(32'hFFFF_FFFF)) dut1 (
        .clk(clk), .reset(reset), .F_PC(F_PC1), .Instr(Instr1),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .D_valid(D_valid1), .D_ready(D_ready), .D_Instr(D_Instr1),
        .D_PC(D_PC1), .fq_count(fq_count1), .halted(halted1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        D_ready     = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (F_PC0 !== 32'h0) begin bad++; $display("FAIL reset_fpc got=%h exp=%h", F_PC0, 32'h0); end
        total++; if (fq_count0 !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fq_count0); end
        total++; if (D_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", D_valid0); end
        total++; if (D_Instr0 !== 32'h0 || D_PC0 !== 32'h0) begin bad++; $display("FAIL reset_d got=%h/%h exp=0/0", D_PC0, D_Instr0); end
        total++; if (halted0 !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted0); end
        total++; if (F_PC1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_fpc1 got=%h exp=ffffffff", F_PC1); end
    endtask

    task automatic test_stream();
        do_reset();
        D_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (D_valid0 !== 1'b1 || D_PC0 !== 32'(i) || D_Instr0 !== 32'h1000 + 32'(i)
                || F_PC0 !== 32'(i + 1) || fq_count0 !== 2'd1) begin
                bad++;
                $display("FAIL stream_%0d got v=%b pc=%h ins=%h fpc=%h cnt=%0d exp v=1 pc=%h ins=%h fpc=%h cnt=1",
                         i, D_valid0, D_PC0, D_Instr0, F_PC0, fq_count0,
                         32'(i), 32'h1000 + 32'(i), 32'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        total++; if (fq_count0 !== 2'd1 || F_PC0 !== 32'd1) begin bad++; $display("FAIL stall_fill1 got cnt=%0d fpc=%h exp cnt=1 fpc=1", fq_count0, F_PC0); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (fq_count0 !== 2'd2 || F_PC0 !== 32'd2 || D_PC0 !== 32'd0 || D_Instr0 !== 32'h1000) begin
                bad++;
                $display("FAIL stall_hold_%0d got cnt=%0d fpc=%h pc=%h ins=%h exp cnt=2 fpc=2 pc=0 ins=1000",
                         i, fq_count0, F_PC0, D_PC0, D_Instr0);
            end
        end
        D_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            total++;
            if (D_valid0 !== 1'b1 || D_PC0 !== 32'(i) || fq_count0 !== 2'd2) begin
                bad++;
                $display("FAIL stall_drain_%0d got v=%b pc=%h cnt=%0d exp v=1 pc=%h cnt=2", i, D_valid0, D_PC0, fq_count0, 32'(i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 32'd4;
        step();
        redirect_en = 1'b0;
        step();
        step();
        total++; if (fq_count0 !== 2'd2 || D_PC0 !== 32'd4) begin bad++; $display("FAIL redir_fill got cnt=%0d pc=%h exp cnt=2 pc=4", fq_count0, D_PC0); end
        redirect_en = 1'b1;
        redirect_pc = 32'd9;
        D_ready     = 1'b1;
        step();
        redirect_en = 1'b0;
        total++; if (D_valid0 !== 1'b0 || fq_count0 !== 2'd0 || F_PC0 !== 32'd9) begin bad++; $display("FAIL redir_flush got v=%b cnt=%0d fpc=%h exp v=0 cnt=0 fpc=9", D_valid0, fq_count0, F_PC0); end
        step();
        total++; if (D_valid0 !== 1'b1 || D_PC0 !== 32'd9 || D_Instr0 !== 32'h1009) begin bad++; $display("FAIL redir_first got v=%b pc=%h ins=%h exp v=1 pc=9 ins=1009", D_valid0, D_PC0, D_Instr0); end
        step();
        total++; if (D_PC0 !== 32'd10) begin bad++; $display("FAIL redir_second got pc=%h exp a", D_PC0); end
    endtask

    task automatic test_halt();
        halt_en   = 1'b1;
        halt_addr = 32'd6;
        do_reset();
        D_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        total++; if (D_PC0 !== 32'd6 || D_Instr0 !== 32'hFFFF_FFFF || D_valid0 !== 1'b1) begin bad++; $display("FAIL halt_deliver got v=%b pc=%h ins=%h exp v=1 pc=6 ins=ffffffff", D_valid0, D_PC0, D_Instr0); end
        total++; if (halted0 !== 1'b1 || F_PC0 !== 32'd6) begin bad++; $display("FAIL halt_state got h=%b fpc=%h exp h=1 fpc=6", halted0, F_PC0); end
        step();
        total++; if (D_valid0 !== 1'b0 || fq_count0 !== 2'd0 || F_PC0 !== 32'd6 || halted0 !== 1'b1) begin bad++; $display("FAIL halt_drain got v=%b cnt=%0d fpc=%h h=%b exp v=0 cnt=0 fpc=6 h=1", D_valid0, fq_count0, F_PC0, halted0); end
        step();
        total++; if (D_valid0 !== 1'b0 || F_PC0 !== 32'd6 || D_PC0 !== 32'd6) begin bad++; $display("FAIL halt_idle got v=%b fpc=%h pc=%h exp v=0 fpc=6 pc=6", D_valid0, F_PC0, D_PC0); end
        redirect_en = 1'b1;
        redirect_pc = 32'd1;
        step();
        redirect_en = 1'b0;
        total++; if (halted0 !== 1'b0 || F_PC0 !== 32'd1 || fq_count0 !== 2'd0) begin bad++; $display("FAIL halt_redir got h=%b fpc=%h cnt=%0d exp h=0 fpc=1 cnt=0", halted0, F_PC0, fq_count0); end
        step();
        total++; if (D_valid0 !== 1'b1 || D_PC0 !== 32'd1 || D_Instr0 !== 32'h1001 || F_PC0 !== 32'd2) begin bad++; $display("FAIL halt_resume got v=%b pc=%h ins=%h fpc=%h exp v=1 pc=1 ins=1001 fpc=2", D_valid0, D_PC0, D_Instr0, F_PC0); end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFFF;
        exp_pc[1] = 32'h0000_0000;
        exp_pc[2] = 32'h0000_0001;
        do_reset();
        D_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (D_valid1 !== 1'b1 || D_PC1 !== exp_pc[i] || D_Instr1 !== 32'h1000 + exp_pc[i] || halted1 !== 1'b0) begin
                bad++;
                $display("FAIL wrap_%0d got v=%b pc=%h ins=%h h=%b exp v=1 pc=%h ins=%h h=0",
                         i, D_valid1, D_PC1, D_Instr1, halted1, exp_pc[i], 32'h1000 + exp_pc[i]);
            end
        end
        total++; if (fq_count1 !== 2'd1) begin bad++; $display("FAIL wrap_count got %0d exp 1", fq_count1); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        step();
        step();
        step();
        total++; if (fq_count0 !== 2'd2) begin bad++; $display("FAIL rstp_full got %0d exp 2", fq_count0); end
        reset       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'd7;
        D_ready     = 1'b1;
        step();
        total++; if (F_PC0 !== 32'h0 || fq_count0 !== 2'd0 || D_valid0 !== 1'b0 || halted0 !== 1'b0) begin bad++; $display("FAIL rstp_state got fpc=%h cnt=%0d v=%b h=%b exp fpc=0 cnt=0 v=0 h=0", F_PC0, fq_count0, D_valid0, halted0); end
        total++; if (F_PC1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rstp_fpc1 got %h exp ffffffff", F_PC1); end
        reset       = 1'b0;
        redirect_en = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        D_ready     = 1'b0;
        halt_en     = 1'b0;
        halt_addr   = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: generates F_PC, drives it into instructionMemory, and captures the returned Instr.
- Buffers fetched words in a 2-entry fetch queue and presents them to decode with a valid/ready handshake.
- Supports PC redirect (branch/jump) with queue flush, and stops fetching on a halt instruction.

Parameters:
- ADDR_WIDTH, 32, width of F_PC / PC values (word address, +1 per instruction)
- INSTR_WIDTH, 32, width of Instr
- RESET_PC, 0, F_PC value after reset
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- F_PC  output  ADDR_WIDTH  fetch address to instructionMemory
- Instr  input  INSTR_WIDTH  instruction word from instructionMemory (combinational read of F_PC)
- redirect_en  input  1  load redirect_pc as next fetch address, flush queue
- redirect_pc  input  ADDR_WIDTH  redirect target
- D_valid  output  1  queue head valid to decode
- D_ready  input  1  decode accepts head this cycle
- D_Instr  output  INSTR_WIDTH  queue head instruction
- D_PC  output  ADDR_WIDTH  address of queue head instruction
- fq_count  output  2  queue occupancy, 0..2
- halted  output  1  fetch stopped on HALT_INSTR

Behaviour:
- Reset (sync, reset=1 at rising edge) values: F_PC=RESET_PC, queue empty, fq_count=0, D_valid=0, D_Instr=0, D_PC=0, halted=0, state=RUN. Reset has priority over all other inputs.
- Instruction memory is combinational: Instr corresponds to the current F_PC in the same cycle.
- pop = D_valid & D_ready. Pop removes the head at the clock edge.
- push = (state==RUN) & ~redirect_en & (fq_count<2 | pop). Push enqueues {F_PC, Instr} at the tail.
- On push: F_PC <= F_PC+1, wrapping modulo 2^ADDR_WIDTH (all-ones -> 0).
- With no push, F_PC holds.
- Queue is FIFO order. D_valid = (fq_count!=0). D_Instr/D_PC show the head and hold stable while D_valid=1 and D_ready=0.
- When the queue is empty, D_Instr and D_PC retain their last values.
- Push and pop in the same cycle are legal at any occupancy:
  - at full, fq_count stays 2 (no bubble);
  - at empty, push and pop cannot coincide (D_valid=0), so the push lands and fq_count becomes 1.
- Fetch-to-decode latency: an instruction fetched at edge N is visible on D_* in cycle N+1.
- States:
  - RUN: fetch as above. If a pushed Instr==HALT_INSTR, it is enqueued normally, then state->HALTED, halted<=1, and F_PC holds at the halt address (no increment on that push).
  - HALTED: no pushes. The queue still drains via pop. Only redirect_en or reset leaves the state.
- Redirect (redirect_en=1 at edge, reset=0):
  - queue flushed (fq_count<=0, D_valid=0 next cycle);
  - any same-cycle pop or push is discarded;
  - F_PC<=redirect_pc, state<=RUN, halted<=0.
  - redirect_pc equal to the current F_PC is legal and refetches it.
- A HALT_INSTR at F_PC in a cycle with redirect_en=1 is not enqueued and does not halt.
- Stall: with the queue full and D_ready=0, F_PC, queue contents, and outputs are all frozen.
- fq_count is never 3. Pop when empty is impossible, since D_valid gates it.

Test Plan:
1. Reset then D_ready=1, memory word i = 32'h1000+i → F_PC counts 0,1,2,3; D_valid rises in cycle 2 after reset release; D_PC/D_Instr sequence 0/1000, 1/1001, 2/1002; fq_count stays 1.
2. D_ready=0 for 5 cycles after reset → fq_count 1 then 2; F_PC frozen at 2; D_PC=0, D_Instr=32'h1000 held. Then D_ready=1 → D_PC 0,1,2 in consecutive cycles with no bubble.
3. Queue holding PCs 4,5, then redirect_en=1, redirect_pc=9 → next cycle D_valid=0, fq_count=0, F_PC=9. The following cycle D_PC=9, and PCs 4 and 5 are never accepted.
4. Word at address 6 = 32'hFFFF_FFFF, D_ready=1 → PC 6 delivered; halted=1; F_PC stays 6; D_valid falls after the drain. Then redirect_pc=1 → halted=0, fetch resumes from 1.
5. RESET_PC = all-ones, D_ready=1 → D_PC sequence FFFF_FFFF, 0000_0000, 0000_0001.
6. reset asserted mid-stream with redirect_en=1 and the queue full → next cycle F_PC=RESET_PC, fq_count=0, D_valid=0, halted=0.
